// File: rtl/rv_soc_top.sv
// ---------------------------------------------------------------------------
// rv_soc_top -- minimal single-cycle RV32I system
//
// Purpose:
//   Instruction ROM + RV32I core (PC, decoder, ALU, register file) + data RAM
//   in separate (Harvard) address spaces. One instruction retires on every
//   rising clock edge while reset is released. Progress is observed through
//   the register file: rv_core_ins.regs_ins.regs[0:31]. The ROM array
//   rom_ins.rom_mem is loaded from outside the design.
//
// Ports (rv_soc_top):
//   clk : input, system clock, all state updates on the rising edge
//   rst : input, asynchronous active-low reset (0 = reset asserted)
//
// Parameters:
//   ROM_DEPTH : instruction words in rom_mem (power of two)
//   RAM_DEPTH : 32-bit data RAM words (power of two)
//   RESET_PC  : PC value held during and after reset
//
// Configuration macro:
//   HALT_ON_ECALL_EN : when defined, ECALL/EBREAK freeze the PC and block all
//                      register and RAM writes until reset. When undefined,
//                      ECALL/EBREAK behave as NOPs.
// ---------------------------------------------------------------------------

// Instruction ROM: combinational read, index wraps modulo ROM_DEPTH.
// Ports: addr (byte address), data (instruction word).
module rv_rom #(
    parameter int ROM_DEPTH = 4096
) (
    input  logic [31:0] addr,
    output logic [31:0] data
);
    localparam int AW = $clog2(ROM_DEPTH);

    logic [31:0] rom_mem [ROM_DEPTH];
    logic        unused_addr_bits;

    assign data             = rom_mem[addr[AW+1:2]];
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
endmodule

// Data RAM: async read, byte-enabled write on the rising edge, no reset.
// Ports: clk, we, be (byte enables), addr (byte address), wdata, rdata.
module rv_ram #(
    parameter int RAM_DEPTH = 4096
) (
    input  logic        clk,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(RAM_DEPTH);

    logic [31:0]   ram_mem [RAM_DEPTH];
    logic [AW-1:0] widx;
    logic          unused_addr_bits;

    assign widx             = addr[AW+1:2];
    assign rdata            = ram_mem[widx];
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram_mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end
endmodule

// Register file: two async read ports, one sync write port, x0 hardwired 0.
// Ports: clk, rst_n, raddr1/rdata1, raddr2/rdata2, we/waddr/wdata.
module rv_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);
    logic [31:0] regs [0:31];

    assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : regs[raddr2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end
endmodule

// Single-cycle RV32I core.
// Ports: clk, rst_n, imem_addr/imem_rdata (fetch), dmem_* (data RAM).
module rv_core #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        dmem_we,
    input  logic [31:0] dmem_rdata
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [31:0] inst;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;
    logic        rd_we;
    logic [31:0] rd_wdata;
    logic        halted;
    logic        imm_valid, reg_valid;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'h0, $signed(a) < $signed(b)};
            3'b011:  r = {31'h0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic br_taken(input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] b);
        logic t;
        case (f3)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) < $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a < b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Halfword/byte lanes are picked from the address low bits; LW ignores them.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[8*lo +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h0, b};
            3'b101:  r = {16'h0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign imem_addr = pc_q;
    assign inst      = imem_rdata;
    assign opcode    = inst[6:0];
    assign rd        = inst[11:7];
    assign funct3    = inst[14:12];
    assign rs1       = inst[19:15];
    assign rs2       = inst[24:20];
    assign funct7    = inst[31:25];
    assign imm_i     = {{20{inst[31]}}, inst[31:20]};
    assign imm_s     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u     = {inst[31:12], 12'h0};
    assign imm_j     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign pc_plus4  = pc_q + 32'd4;
    assign dmem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

    // Encodings with funct7 bits outside the base ISA are treated as unknown.
    assign imm_valid = (funct3 == 3'b001) ? (funct7 == 7'h00) :
                       (funct3 == 3'b101) ? ((funct7 == 7'h00) || (funct7 == 7'h20)) : 1'b1;
    assign reg_valid = (funct7 == 7'h00) ||
                       ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

`ifdef HALT_ON_ECALL_EN
    logic halt_q, halt_d;

    // The halting instruction itself already suppresses its own effects.
    assign halted = halt_q || (inst == 32'h00000073) || (inst == 32'h00100073);
    assign halt_d = halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halt_q <= 1'b0;
        else        halt_q <= halt_d;
    end
`else
    assign halted = 1'b0;
`endif

    rv_regfile regs_ins (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (rs1),
        .rdata1 (rs1_val),
        .raddr2 (rs2),
        .rdata2 (rs2_val),
        .we     (rd_we),
        .waddr  (rd),
        .wdata  (rd_wdata)
    );

    always_comb begin
        pc_d       = pc_plus4;
        rd_we      = 1'b0;
        rd_wdata   = 32'h0;
        dmem_we    = 1'b0;
        dmem_be    = 4'h0;
        dmem_wdata = 32'h0;
        case (opcode)
            OP_LUI: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OP_AUIPC: begin
                rd_we    = 1'b1;
                rd_wdata = pc_q + imm_u;
            end
            OP_JAL: begin
                rd_we    = 1'b1;
                rd_wdata = pc_plus4;
                pc_d     = pc_q + imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    rd_we    = 1'b1;
                    rd_wdata = pc_plus4;
                    pc_d     = (rs1_val + imm_i) & ~32'h1;
                end
            end
            OP_BRANCH: begin
                if (br_taken(funct3, rs1_val, rs2_val)) pc_d = pc_q + imm_b;
            end
            OP_LOAD: begin
                if ((funct3 != 3'b011) && (funct3 [2:1] != 2'b11)) begin
                    rd_we    = 1'b1;
                    rd_wdata = load_ext(funct3, dmem_addr[1:0], dmem_rdata);
                end
            end
            OP_STORE: begin
                case (funct3)
                    3'b000: begin
                        dmem_we    = 1'b1;
                        dmem_be    = 4'b0001 << dmem_addr[1:0];
                        dmem_wdata = {4{rs2_val[7:0]}};
                    end
                    3'b001: begin
                        dmem_we    = 1'b1;
                        dmem_be    = dmem_addr[1] ? 4'b1100 : 4'b0011;
                        dmem_wdata = {2{rs2_val[15:0]}};
                    end
                    3'b010: begin
                        dmem_we    = 1'b1;
                        dmem_be    = 4'b1111;
                        dmem_wdata = rs2_val;
                    end
                    default: ;
                endcase
            end
            OP_IMM: begin
                if (imm_valid) begin
                    rd_we    = 1'b1;
                    rd_wdata = alu(funct3, (funct3 == 3'b101) && inst[30], rs1_val, imm_i);
                end
            end
            OP_REG: begin
                if (reg_valid) begin
                    rd_we    = 1'b1;
                    rd_wdata = alu(funct3, funct7[5], rs1_val, rs2_val);
                end
            end
            default: ;
        endcase
        if (halted) begin
            pc_d    = pc_q;
            rd_we   = 1'b0;
            dmem_we = 1'b0;
        end
        // The RAM has no reset of its own, so block stores while reset is held.
        if (!rst_n) dmem_we = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end
endmodule

module rv_soc_top #(
    parameter int          ROM_DEPTH = 4096,
    parameter int          RAM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input logic clk,
    input logic rst
);
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_we;

    rv_rom #(.ROM_DEPTH(ROM_DEPTH)) rom_ins (
        .addr (imem_addr),
        .data (imem_rdata)
    );

    rv_core #(.RESET_PC(RESET_PC)) rv_core_ins (
        .clk        (clk),
        .rst_n      (rst),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_we    (dmem_we),
        .dmem_rdata (dmem_rdata)
    );

    rv_ram #(.RAM_DEPTH(RAM_DEPTH)) ram_ins (
        .clk   (clk),
        .we    (dmem_we),
        .be    (dmem_be),
        .addr  (dmem_addr),
        .wdata (dmem_wdata),
        .rdata (dmem_rdata)
    );
endmodule

// File: tb/tb_rv_soc_top.sv
module tb_rv_soc_top;
    localparam int ROM_DEPTH = 4096;
    localparam int OPI = 7'h13, LD = 7'h03, JALR = 7'h67, LUI = 7'h37, AUIPC = 7'h17;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    typedef struct {
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog[$];

    rv_soc_top #(.ROM_DEPTH(ROM_DEPTH), .RAM_DEPTH(4096), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input int op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 0, rd, OPI);
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v;
        v = imm;
        return {v[11:5], rs2[4:0], rs1[4:0], f3[2:0], v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], rs2[4:0], rs1[4:0], f3[2:0], v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
        logic [31:0] v;
        v = imm20;
        return {v[19:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], rd[4:0], 7'h6F};
    endfunction

    // ---------------- probes and infrastructure ----------------
    function automatic logic [31:0] rd_reg(input int i);
        logic [4:0] k;
        k = i[4:0];
        return dut.rv_core_ins.regs_ins.regs[k];
    endfunction

    function automatic logic [31:0] rd_pc();
        return dut.rv_core_ins.pc_q;
    endfunction

    task automatic expect_reg(input int idx, input logic [31:0] val);
        exp_t e;
        e.idx = idx;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic push_end();
        prog.push_back(addi(27, 0, 1));
        prog.push_back(addi(26, 0, 1));
        prog.push_back(enc_j(0, 0));
    endtask

    task automatic load_prog();
        logic [11:0] k;
        for (int i = 0; i < ROM_DEPTH; i++) begin
            k = i[11:0];
            dut.rom_ins.rom_mem[k] = 32'h00000013;
        end
        for (int i = 0; i < prog.size(); i++) begin
            k = i[11:0];
            dut.rom_ins.rom_mem[k] = prog[i];
        end
        prog.delete();
    endtask

    // Reset released 5 ns before a rising edge; that edge executes rom_mem[0].
    task automatic apply_reset();
        @(posedge clk);
        #5 rst = 1'b0;
        #30 rst = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        bit done;
        done = 1'b0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            @(posedge clk);
            #1;
            if (rd_reg(26) != 32'h0) done = 1'b1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s done-timeout: x26 got %h, required nonzero within %0d cycles",
                     tag, rd_reg(26), max_cycles);
        end
        vectors++;
        if (rd_reg(27) !== 32'h1) begin
            miscompares++;
            $display("FAIL %s pass-flag: x27 got %h required 00000001", tag, rd_reg(27));
            for (int i = 0; i < 32; i += 4)
                $display("  x%0d..x%0d: %h %h %h %h", i, i + 3, rd_reg(i), rd_reg(i + 1),
                         rd_reg(i + 2), rd_reg(i + 3));
        end
    endtask

    task automatic drain_sb(input string tag);
        exp_t        e;
        logic [31:0] got;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = rd_reg(e.idx);
            vectors++;
            if (got !== e.val) begin
                miscompares++;
                $display("FAIL %s x%0d: got %h required %h", tag, e.idx, got, e.val);
            end
        end
    endtask

    task automatic check_pc(input string tag, input logic [31:0] exp_pc);
        vectors++;
        if (rd_pc() !== exp_pc) begin
            miscompares++;
            $display("FAIL %s pc: got %h required %h", tag, rd_pc(), exp_pc);
        end
    endtask

    task automatic check_regs_zero(input string tag);
        int bad;
        bad = -1;
        for (int i = 31; i >= 0; i--) if (rd_reg(i) !== 32'h0) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s regs-clear: x%0d got %h required 00000000", tag, bad, rd_reg(bad));
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        prog.push_back(addi(5, 0, 12'h123));
        prog.push_back(addi(6, 0, 12'h456));
        load_prog();
        @(posedge clk);
        #5 rst = 1'b0;
        #1;
        check_pc("reset-held", 32'h0);
        check_regs_zero("reset-held");
        #29 rst = 1'b1;
        @(posedge clk);
        #1;
        expect_reg(5, 32'h00000123);
        expect_reg(6, 32'h00000000);
        drain_sb("first-fetch");
        check_pc("first-fetch", 32'h4);
    endtask

    task automatic test_alu();
        prog.push_back(addi(1, 0, -1));
        prog.push_back(enc_i(28, 1, 5, 2, OPI));
        prog.push_back(enc_i(12'h400 | 28, 1, 5, 3, OPI));
        prog.push_back(enc_r(0, 1, 0, 3, 4));
        prog.push_back(addi(5, 0, 12'h7FF));
        prog.push_back(enc_u(20'h80000, 6, LUI));
        prog.push_back(enc_r(0, 6, 6, 0, 7));
        prog.push_back(enc_r(7'h20, 5, 0, 0, 8));
        prog.push_back(enc_r(0, 5, 8, 2, 9));
        prog.push_back(enc_r(0, 5, 8, 3, 10));
        prog.push_back(enc_r(0, 1, 5, 1, 11));
        prog.push_back(enc_r(0, 1, 6, 5, 12));
        prog.push_back(enc_r(7'h20, 2, 6, 5, 13));
        prog.push_back(enc_r(0, 1, 5, 4, 14));
        prog.push_back(enc_r(0, 6, 5, 6, 15));
        prog.push_back(enc_r(0, 5, 1, 7, 16));
        prog.push_back(enc_i(-2046, 8, 2, 17, OPI));
        prog.push_back(enc_i(1, 0, 3, 18, OPI));
        prog.push_back(enc_i(-1, 5, 4, 19, OPI));
        prog.push_back(enc_i(12'h555, 0, 6, 20, OPI));
        prog.push_back(enc_i(12'h0F0, 1, 7, 21, OPI));
        prog.push_back(enc_i(4, 5, 1, 22, OPI));
        prog.push_back(enc_u(1, 23, AUIPC));
        prog.push_back(32'h0000000F);
        prog.push_back(32'h00000F8B);
        prog.push_back(enc_r(1, 5, 5, 0, 30));
        push_end();
        load_prog();
        expect_reg(1, 32'hFFFFFFFF);
        expect_reg(2, 32'h0000000F);
        expect_reg(3, 32'hFFFFFFFF);
        expect_reg(4, 32'h00000001);
        expect_reg(7, 32'h00000000);
        expect_reg(8, 32'hFFFFF801);
        expect_reg(9, 32'h00000001);
        expect_reg(10, 32'h00000000);
        expect_reg(11, 32'h80000000);
        expect_reg(12, 32'h00000001);
        expect_reg(13, 32'hFFFF0000);
        expect_reg(14, 32'hFFFFF800);
        expect_reg(15, 32'h800007FF);
        expect_reg(16, 32'h000007FF);
        expect_reg(17, 32'h00000001);
        expect_reg(18, 32'h00000001);
        expect_reg(19, 32'hFFFFF800);
        expect_reg(20, 32'h00000555);
        expect_reg(21, 32'h000000F0);
        expect_reg(22, 32'h00007FF0);
        expect_reg(23, 32'h00001058);
        expect_reg(30, 32'h00000000);
        expect_reg(31, 32'h00000000);
        apply_reset();
        wait_done("alu", 200);
        drain_sb("alu");
    endtask

    task automatic test_x0();
        prog.push_back(addi(5, 0, 9));
        prog.push_back(addi(0, 0, 5));
        prog.push_back(enc_r(0, 0, 0, 0, 5));
        push_end();
        load_prog();
        expect_reg(0, 32'h0);
        expect_reg(5, 32'h0);
        apply_reset();
        wait_done("x0", 100);
        drain_sb("x0");
    endtask

    task automatic test_memory();
        prog.push_back(enc_u(20'h80, 6, LUI));
        prog.push_back(addi(7, 0, -128));
        prog.push_back(enc_s(0, 7, 0, 2));
        prog.push_back(enc_i(0, 0, 0, 8, LD));
        prog.push_back(enc_i(0, 0, 4, 9, LD));
        prog.push_back(enc_i(2, 0, 1, 10, LD));
        prog.push_back(addi(11, 0, 12'h5A));
        prog.push_back(enc_s(4, 0, 0, 2));
        prog.push_back(enc_s(5, 11, 0, 0));
        prog.push_back(enc_i(4, 0, 2, 12, LD));
        prog.push_back(enc_s(6, 7, 0, 1));
        prog.push_back(enc_i(6, 0, 5, 13, LD));
        prog.push_back(enc_i(7, 0, 2, 14, LD));
        prog.push_back(enc_i(5, 0, 1, 15, LD));
        prog.push_back(enc_u(4, 17, LUI));
        prog.push_back(enc_s(0, 11, 17, 2));
        prog.push_back(enc_i(0, 0, 2, 16, LD));
        prog.push_back(enc_i(5, 0, 0, 18, LD));
        push_end();
        load_prog();
        expect_reg(6, 32'h00080000);
        expect_reg(8, 32'hFFFFFF80);
        expect_reg(9, 32'h00000080);
        expect_reg(10, 32'hFFFFFFFF);
        expect_reg(12, 32'h00005A00);
        expect_reg(13, 32'h0000FF80);
        expect_reg(14, 32'hFF805A00);
        expect_reg(15, 32'h00005A00);
        expect_reg(16, 32'h0000005A);
        expect_reg(18, 32'h0000005A);
        apply_reset();
        wait_done("mem", 200);
        drain_sb("mem");
    endtask

    task automatic test_control();
        prog.push_back(addi(20, 0, 0));          // 00
        prog.push_back(enc_b(8, 0, 0, 0));       // 04 BEQ -> 0C
        prog.push_back(addi(20, 0, 99));         // 08
        prog.push_back(addi(21, 0, -1));         // 0C
        prog.push_back(enc_b(8, 0, 21, 4));      // 10 BLT taken -> 18
        prog.push_back(addi(20, 20, 1));         // 14
        prog.push_back(enc_b(8, 0, 21, 6));      // 18 BLTU not taken
        prog.push_back(addi(22, 0, 7));          // 1C
        prog.push_back(enc_j(12, 1));            // 20 JAL x1 -> 2C
        prog.push_back(enc_j(20, 0));            // 24 JAL -> 38
        prog.push_back(addi(20, 0, 55));         // 28
        prog.push_back(addi(23, 0, 3));          // 2C
        prog.push_back(enc_i(0, 1, 0, 0, JALR)); // 30 JALR -> 24
        prog.push_back(addi(20, 0, 66));         // 34
        prog.push_back(enc_b(8, 22, 23, 1));     // 38 BNE taken -> 40
        prog.push_back(addi(20, 0, 77));         // 3C
        prog.push_back(enc_b(8, 21, 0, 5));      // 40 BGE taken -> 48
        prog.push_back(addi(20, 0, 88));         // 44
        prog.push_back(enc_b(8, 21, 0, 7));      // 48 BGEU not taken
        prog.push_back(addi(24, 0, 1));          // 4C
        prog.push_back(enc_i(12'h35, 1, 0, 25, JALR)); // 50 -> (0x59 & ~1) = 58
        prog.push_back(addi(20, 0, 44));         // 54
        push_end();                              // 58
        load_prog();
        expect_reg(1, 32'h00000024);
        expect_reg(20, 32'h00000000);
        expect_reg(21, 32'hFFFFFFFF);
        expect_reg(22, 32'h00000007);
        expect_reg(23, 32'h00000003);
        expect_reg(24, 32'h00000001);
        expect_reg(25, 32'h00000054);
        apply_reset();
        repeat (7) @(posedge clk);
        #1;
        check_pc("jal-target", 32'h2C);
        repeat (2) @(posedge clk);
        #1;
        check_pc("jalr-target", 32'h24);
        wait_done("ctrl", 100);
        drain_sb("ctrl");
    endtask

    task automatic test_mid_reset();
        prog.push_back(addi(1, 1, 1));
        prog.push_back(enc_j(-4, 0));
        load_prog();
        apply_reset();
        repeat (10) @(posedge clk);
        #1;
        expect_reg(1, 32'd5);
        drain_sb("loop");
        #4 rst = 1'b0;
        #1;
        check_pc("mid-reset", 32'h0);
        check_regs_zero("mid-reset");
        prog.push_back(enc_i(4, 0, 2, 2, LD));
        push_end();
        load_prog();
        expect_reg(2, 32'hFF805A00);
        apply_reset();
        wait_done("ram-kept", 50);
        drain_sb("ram-kept");
    endtask

    task automatic test_ecall();
        prog.push_back(addi(1, 0, 1));
        prog.push_back(32'h00000013);
        prog.push_back(32'h00000013);
        prog.push_back(32'h00000013);
        prog.push_back(32'h00000073);            // 10 ECALL
        prog.push_back(addi(2, 0, 2));
        push_end();
        load_prog();
        expect_reg(1, 32'h1);
        apply_reset();
`ifdef HALT_ON_ECALL_EN
        expect_reg(2, 32'h0);
        expect_reg(26, 32'h0);
        repeat (40) @(posedge clk);
        #1;
        check_pc("ecall-halt", 32'h10);
        drain_sb("ecall-halt");
`else
        expect_reg(2, 32'h2);
        repeat (5) @(posedge clk);
        #1;
        check_pc("ecall-nop", 32'h14);
        wait_done("ecall-nop", 50);
        drain_sb("ecall-nop");
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        test_reset();
        test_alu();
        test_x0();
        test_memory();
        test_control();
        test_mid_reset();
        test_ecall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
